vgafb_pixel_fetch: RTL
======================

Name: vgafb_pixel_fetch

Overview:
Pixel-clock-domain fetch and serializer engine for the framebuffer. It prefetches video-memory words into a small FIFO and serializes them into palette indices at 1/2/4/8 bits per pixel. It supports optional horizontal and vertical pixel doubling, a programmable frame base address and line stride. It sits between the display timing generator, the pixel port of the video BRAM and the palette lookup.

Parameters:
DATA_WIDTH, 32, video memory word width; must be a multiple of 8
ADDR_WIDTH, 15, video memory word address width
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, ≥ READ_LATENCY+1)
READ_LATENCY, 1, cycles from o_mem_rd to i_mem_data valid (≥1)

Ports:
i_pix_clk  in  1  pixel clock
i_rst  in  1  asynchronous active-high reset
i_mode  in  2  bits per pixel: 0=1, 1=2, 2=4, 3=8
i_hdouble  in  1  each pixel shown for 2 clocks
i_vdouble  in  1  each memory line shown on 2 scanlines
i_base_addr  in  ADDR_WIDTH  word address of first pixel of frame
i_stride  in  ADDR_WIDTH  words between successive memory lines
i_frame  in  1  one-tick frame-start strobe from timing generator
i_scanline  in  1  one-tick strobe before each visible line
i_de  in  1  display enable
i_mem_ready  in  1  pixel port may accept a read this cycle
o_mem_rd  out  1  read request
o_mem_addr  out  ADDR_WIDTH  read word address
i_mem_data  in  DATA_WIDTH  read data, READ_LATENCY after accepted request
o_pixel  out  8  palette index, zero-extended, registered
o_pixel_valid  out  1  i_de delayed 1 clock
o_underrun  out  1  sticky: pixel needed while no data available
i_clr_underrun  in  1  clears o_underrun

Behaviour:
- Reset (async, i_rst=1): all outputs 0. FIFO, shifter, in-flight pipe and line counters empty/zero. Shadow config = 0. Fetch disabled.
- Shadow config: on i_frame, latch i_mode, i_hdouble, i_vdouble, i_base_addr, i_stride. Changes mid-frame have no effect until the next i_frame.
- On i_frame: line_addr <= i_base_addr. vphase <= 0. Flush FIFO, shifter and in-flight pipe. Fetch disabled.
- On i_scanline:
  - fetch_addr <= line_addr.
  - Flush FIFO, shifter and in-flight pipe.
  - Fetch enabled.
  - If shadow vdouble=0 or vphase=1: line_addr += stride. Otherwise line_addr is held.
  - vphase toggles when vdouble=1 and stays 0 otherwise.
- If i_frame and i_scanline are asserted together, frame processing applies first and the scanline then uses the new base.
- Fetch: o_mem_rd=1 when fetch enabled, i_mem_ready=1, and (FIFO count + in-flight) < FIFO_DEPTH. o_mem_addr=fetch_addr. fetch_addr increments on each issued read, wrapping modulo 2^ADDR_WIDTH. o_mem_rd and o_mem_addr are combinational from registered state.
- In-flight tracking: a READ_LATENCY-deep valid shift pipe. An entry exiting the pipe writes i_mem_data into the FIFO. A flush clears the pipe, so stale returns are discarded. The FIFO can never overflow by construction.
- Shifter:
  - ppw = DATA_WIDTH >> log2(bpp).
  - Pixels are taken MSB-first.
  - When the shifter is empty and the FIFO is non-empty, load a word in any cycle, including blanking, so the first word is preloaded before i_de.
  - During i_de, a pixel is consumed every clock, or every 2nd clock when hdouble=1.
  - Consuming the last pixel of a word reloads from the FIFO in the same cycle if the FIFO is non-empty; otherwise the shifter becomes empty.
- Output: o_pixel <= (i_de && shifter non-empty) ? top bpp bits zero-extended : 0. o_pixel_valid <= i_de. Latency from i_de to first pixel is exactly 1 clock; the integrator delays sync by 1.
- Underrun: i_de=1 with the shifter empty sets o_underrun and outputs pixel 0. Set has priority over i_clr_underrun in the same cycle.
- Pixel doubling phase resets at every i_scanline.

Test Plan:
- Mode 2 (4bpp), DATA_WIDTH 32, word 0x01234567 at base 0, i_mem_ready=1, i_de for 8 clocks after i_scanline -> o_pixel 0,1,…,7 on consecutive clocks starting 1 clock after i_de; o_underrun=0.
- Mode 0 (1bpp), word 0xA0000000, hdouble=1 -> o_pixel 1,1,0,0,1,1,0,0…; mode 3 (8bpp), words 0x11223344,0x55667788 -> pixels 0x11,0x22,…,0x88 with no gap across the word boundary.
- base=0x100, stride=0x28, vdouble=0, three i_scanline strobes -> first o_mem_addr per line = 0x100, 0x128, 0x150. With vdouble=1 -> 0x100, 0x100, 0x128. Base 0x7FFF with stride 1 wraps to 0x0000.
- Change i_mode and i_base_addr mid-frame -> pixel output and fetch addresses are unchanged until the next i_frame, then use the new values.
- Hold i_mem_ready=0 from i_scanline, assert i_de -> o_pixel=0, o_underrun=1 and stays 1 after i_mem_ready returns. i_clr_underrun clears it. Set and clear in the same cycle -> stays 1.
- Assert i_scanline while reads are in flight (READ_LATENCY=3) -> stale returns are not written to the FIFO, and the first pixel of the new line comes from the new line_addr. Assert i_rst mid-line -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/vgafb_pixel_fetch.sv
// vgafb_pixel_fetch: prefetches video words into a FIFO and serializes them into 1/2/4/8 bpp palette indices.
module vgafb_pixel_fetch #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_pix_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_mode,
  input  logic                  i_hdouble,
  input  logic                  i_vdouble,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic                  i_frame,
  input  logic                  i_scanline,
  input  logic                  i_de,
  input  logic                  i_mem_ready,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [7:0]            o_pixel,
  output logic                  o_pixel_valid,
  output logic                  o_underrun,
  input  logic                  i_clr_underrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(DATA_WIDTH + 1);

  logic [1:0]              mode_q;
  logic                    hdbl, vdbl, vphase, hphase, fetch_en;
  logic [ADDR_WIDTH-1:0]   stride_q, line_addr, fetch_addr;
  logic [DATA_WIDTH-1:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt, infl;
  logic [READ_LATENCY-1:0] pipe;
  logic [DATA_WIDTH-1:0]   sh;
  logic [SW-1:0]           sh_left, ppw;
  logic [7:0]              pix;
  logic                    flush, ret, consume, load;
  logic                    f_vdbl, f_vph;
  logic [ADDR_WIDTH-1:0]   f_line, f_stride;

  always_comb begin
    flush      = i_frame | i_scanline;
    ret        = pipe[READ_LATENCY-1];
    o_mem_rd   = fetch_en && i_mem_ready && (({1'b0, cnt} + {1'b0, infl}) < (CW+1)'(FIFO_DEPTH));
    o_mem_addr = fetch_addr;
    ppw        = SW'(DATA_WIDTH >> mode_q);
    consume    = i_de && sh_left != '0 && (!hdbl || hphase);
    load       = cnt != '0 && (sh_left == '0 || (consume && sh_left == SW'(1)));
    pix        = sh[DATA_WIDTH-1 -: 8] >> (4'd8 - (4'd1 << mode_q));
    // a frame strobe coinciding with a scanline strobe is applied first
    f_line     = i_frame ? i_base_addr : line_addr;
    f_stride   = i_frame ? i_stride : stride_q;
    f_vdbl     = i_frame ? i_vdouble : vdbl;
    f_vph      = i_frame ? 1'b0 : vphase;
  end

  always_ff @(posedge i_pix_clk)
    if (ret && !flush) fifo[wr_ptr] <= i_mem_data;

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q        <= '0;
      hdbl          <= 1'b0;
      vdbl          <= 1'b0;
      stride_q      <= '0;
      line_addr     <= '0;
      fetch_addr    <= '0;
      vphase        <= 1'b0;
      hphase        <= 1'b0;
      fetch_en      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      infl          <= '0;
      pipe          <= '0;
      sh            <= '0;
      sh_left       <= '0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      if (i_frame) begin
        mode_q    <= i_mode;
        hdbl      <= i_hdouble;
        vdbl      <= i_vdouble;
        stride_q  <= i_stride;
        line_addr <= i_base_addr;
        vphase    <= 1'b0;
        fetch_en  <= 1'b0;
      end
      if (i_scanline) begin
        fetch_addr <= f_line;
        fetch_en   <= 1'b1;
        line_addr  <= (!f_vdbl || f_vph) ? f_line + f_stride : f_line;
        vphase     <= f_vdbl & ~f_vph;
        hphase     <= 1'b0;
      end else begin
        if (o_mem_rd) fetch_addr <= fetch_addr + 1'b1;
        if (i_de && hdbl) hphase <= ~hphase;
      end
      if (flush) begin
        pipe    <= '0;
        infl    <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        sh      <= '0;
        sh_left <= '0;
      end else begin
        pipe <= (pipe << 1) | READ_LATENCY'(o_mem_rd);
        infl <= infl + CW'(o_mem_rd) - CW'(ret);
        if (ret) wr_ptr <= wr_ptr + 1'b1;
        if (load) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(ret) - CW'(load);
        if (load) begin
          sh      <= fifo[rd_ptr];
          sh_left <= ppw;
        end else if (consume) begin
          sh      <= sh << (4'd1 << mode_q);
          sh_left <= sh_left - 1'b1;
        end
      end
      o_pixel       <= (i_de && sh_left != '0) ? pix : 8'd0;
      o_pixel_valid <= i_de;
      o_underrun    <= (i_de && sh_left == '0) ? 1'b1 : i_clr_underrun ? 1'b0 : o_underrun;
    end
  end
endmodule
